// File: rtl/serial_tx_buffer.sv
// serial_tx_buffer: byte FIFO that drains into a UART transmitter.
// Accepts bytes from the processor's serial write strobe and applies backpressure
// through ready_out. It shifts each byte out LSB first as an 8N1 frame on tx_out.
// Build option: define SERIAL_TX_PARITY_EN to insert an even-parity bit between the
// data bits and the stop bit, which makes the frame 8E1.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to hold a byte
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | shift[0] on the line, eight bits, each CLKS_PER_BIT cycles
// PARITY | even parity of the byte (only with SERIAL_TX_PARITY_EN)
// STOP   | stop bit (high); chains straight into START if more bytes wait

module serial_tx_buffer #(
   parameter int DEPTH        = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [7:0]             data_in,
   input  logic                   wren_in,
   output logic                   ready_out,
   output logic                   tx_out,
   output logic                   busy_out,
   output logic [$clog2(DEPTH):0] count_out,
   output logic                   overflow_out
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int TIMER_W = $clog2(CLKS_PER_BIT);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3
`ifdef SERIAL_TX_PARITY_EN
      , S_PARITY = 3'd4
`endif
   } state_t;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [7:0]       head;

   state_t           state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             timer_done;
`ifdef SERIAL_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot early.
   assign full      = (count_q == CNT_FULL);
   assign empty     = (count_q == '0);
   assign push      = wren_in && !full;
   assign head      = mem[rd_ptr_q];

   assign ready_out    = !full;
   assign tx_out       = tx_q;
   assign count_out    = count_q;
   assign overflow_out = overflow_q;
   assign busy_out     = (state_q != S_IDLE) || !empty;

   // FIFO storage, pointers, occupancy and sticky overflow
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr_q] <= data_in;
            wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (wren_in && full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Transmitter state register; tx is registered from the next-state decode
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state, bit timing, FIFO pop and line level
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      pop        = 1'b0;
      tx_d       = 1'b1;
      timer_done = (timer_q == TIMER_LAST);
`ifdef SERIAL_TX_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               timer_d = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (timer_done) begin
               timer_d = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         S_DATA: begin
            if (timer_done) begin
               timer_d = '0;
               if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: begin
            if (timer_done) begin
               timer_d = '0;
               state_d = S_STOP;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (timer_done) begin
               timer_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase

`ifdef SERIAL_TX_PARITY_EN
      // The shift register is consumed bit by bit, so parity is captured at load time
      if (pop) begin
         parity_d = ^head;
      end
`endif

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_serial_tx_buffer.sv
// Testbench for serial_tx_buffer with DEPTH=4 and CLKS_PER_BIT=4.
// Stimulus pushes each expected frame as {parity, byte} onto exp_q. A UART monitor
// decodes tx_out on its own and checks every completed frame against the queue head.
// Define SERIAL_TX_PARITY_EN to exercise the parity build.

module tb_serial_tx_buffer;

   localparam int DEPTH = 4;
   localparam int CPB   = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CPB;

   logic       clock;
   logic       reset;
   logic [7:0] data_in;
   logic       wren_in;
   logic       ready_out;
   logic       tx_out;
   logic       busy_out;
   logic [2:0] count_out;
   logic       overflow_out;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int frames_done = 0;
   int n_aborts = 0;
   bit mon_busy = 0;

   logic [8:0] exp_q [$];
   int         starts [$];

   serial_tx_buffer #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clock        (clock),
      .reset        (reset),
      .data_in      (data_in),
      .wren_in      (wren_in),
      .ready_out    (ready_out),
      .tx_out       (tx_out),
      .busy_out     (busy_out),
      .count_out    (count_out),
      .overflow_out (overflow_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int t);
      int n = 0;
      while (cyc < t && n < 2000) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
         @(posedge clock); #1;
         n++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
   endtask

   // UART monitor: decodes frames from tx_out and scores them against exp_q
   logic samp [FRAME_CYC];
   initial begin
      forever begin
         @(posedge clock); #1;
         if (!reset && tx_out === 1'b0) begin
            int  st;
            bit  aborted;
            bit  stable;
            logic [7:0] data;
            logic [8:0] e;
            mon_busy = 1;
            aborted  = 0;
            st       = cyc;
            samp[0]  = 1'b0;
            for (int i = 1; i < FRAME_CYC; i++) begin
               @(posedge clock); #1;
               if (reset) begin
                  aborted = 1;
                  break;
               end
               samp[i] = tx_out;
            end
            if (aborted) begin
               n_aborts++;
            end else begin
               stable = 1;
               for (int b = 0; b < FRAME_BITS; b++)
                  for (int j = 1; j < CPB; j++)
                     if (samp[b*CPB+j] !== samp[b*CPB]) stable = 0;
               for (int b = 0; b < 8; b++) data[b] = samp[(b+1)*CPB];
               starts.push_back(st);
               frames_done++;
               chk("frame_bits_stable", {31'd0, stable}, 1);
               chk("frame_start_bit", {31'd0, samp[0]}, 0);
               chk("frame_stop_bit", {31'd0, samp[(FRAME_BITS-1)*CPB]}, 1);
               chk("frame_expected", {31'd0, exp_q.size() != 0}, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("frame_data", {24'd0, data}, {24'd0, e[7:0]});
`ifdef SERIAL_TX_PARITY_EN
                  chk("frame_parity", {31'd0, samp[9*CPB]}, {31'd0, e[8]});
`endif
               end
            end
            mon_busy = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int lows;
      int fd;
      reset   = 1'b1;
      wren_in = 1'b0;
      data_in = 8'h00;

      // 1: reset held 20 cycles
      repeat (10) @(posedge clock);
      #1;
      chk("rst_tx", {31'd0, tx_out}, 1);
      chk("rst_ready", {31'd0, ready_out}, 1);
      chk("rst_count", {29'd0, count_out}, 0);
      chk("rst_overflow", {31'd0, overflow_out}, 0);
      chk("rst_busy", {31'd0, busy_out}, 0);
      repeat (10) @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("post_rst_tx", {31'd0, tx_out}, 1);
      chk("post_rst_ready", {31'd0, ready_out}, 1);
      chk("post_rst_count", {29'd0, count_out}, 0);
      chk("post_rst_overflow", {31'd0, overflow_out}, 0);
      chk("post_rst_busy", {31'd0, busy_out}, 0);

      // 2: single write A5 (bits LSB first 1,0,1,0,0,1,0,1; even parity 0)
      starts.delete();
      @(negedge clock);
      data_in = 8'hA5;
      wren_in = 1'b1;
      exp_q.push_back({1'b0, 8'hA5});
      @(posedge clock); #1;
      acc = cyc;
      chk("a5_count_after_accept", {29'd0, count_out}, 1);
      chk("a5_tx_idle_at_accept", {31'd0, tx_out}, 1);
      @(negedge clock);
      wren_in = 1'b0;
      @(posedge clock); #1;
      chk("a5_tx_start_latency", {31'd0, tx_out}, 0);
      chk("a5_count_after_pop", {29'd0, count_out}, 0);
      chk("a5_busy_in_frame", {31'd0, busy_out}, 1);
      wait_until(acc + FRAME_CYC);
      chk("a5_busy_last_stop", {31'd0, busy_out}, 1);
      chk("a5_tx_stop", {31'd0, tx_out}, 1);
      wait_until(acc + FRAME_CYC + 1);
      chk("a5_busy_after_stop", {31'd0, busy_out}, 0);
      wait_drain(200);
      chk("a5_start_cycle", (starts.size() > 0) ? starts[0] : -1, acc + 1);

      // 3+4: five writes with wren held high, then one write while full
      repeat (3) @(posedge clock);
      starts.delete();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clock);
         data_in = 8'(i);
         wren_in = 1'b1;
      end
      exp_q.push_back({1'b1, 8'h01});
      exp_q.push_back({1'b1, 8'h02});
      exp_q.push_back({1'b0, 8'h03});
      exp_q.push_back({1'b1, 8'h04});
      exp_q.push_back({1'b0, 8'h05});
      @(posedge clock); #1;
      acc = cyc - 4;
      chk("burst_count_full", {29'd0, count_out}, 4);
      chk("burst_ready_low", {31'd0, ready_out}, 0);
      chk("burst_no_overflow", {31'd0, overflow_out}, 0);
      @(negedge clock);
      data_in = 8'hEE;
      @(posedge clock); #1;
      chk("full_write_overflow", {31'd0, overflow_out}, 1);
      chk("full_write_count", {29'd0, count_out}, 4);
      @(negedge clock);
      wren_in = 1'b0;
      wait_drain(600);
      chk("burst_frame_count", starts.size(), 5);
      chk("burst_first_start", (starts.size() > 0) ? starts[0] : -1, acc + 1);
      for (int i = 1; i < starts.size(); i++)
         chk("burst_back_to_back_gap", starts[i] - starts[i-1], FRAME_CYC);
      chk("overflow_sticky", {31'd0, overflow_out}, 1);
      chk("ready_after_drain", {31'd0, ready_out}, 1);

      // 5: reset mid-DATA of FF with two bytes queued
      repeat (3) @(posedge clock);
      fd = frames_done;
      foreach (exp_q[i]) exp_q.delete(i);
      @(negedge clock);
      data_in = 8'hFF;
      wren_in = 1'b1;
      @(negedge clock);
      data_in = 8'h11;
      @(negedge clock);
      data_in = 8'h22;
      @(posedge clock); #1;
      acc = cyc - 2;
      chk("abort_queued_count", {29'd0, count_out}, 2);
      @(negedge clock);
      wren_in = 1'b0;
      wait_until(acc + 12);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("abort_tx", {31'd0, tx_out}, 1);
      chk("abort_count", {29'd0, count_out}, 0);
      chk("abort_busy", {31'd0, busy_out}, 0);
      chk("abort_overflow_cleared", {31'd0, overflow_out}, 0);
      @(negedge clock);
      reset = 1'b0;
      lows = 0;
      repeat (100) begin
         @(posedge clock); #1;
         if (tx_out !== 1'b1) lows++;
      end
      chk("abort_tx_stays_idle", lows, 0);
      chk("abort_no_frames", frames_done - fd, 0);
      chk("abort_frame_seen_aborted", n_aborts, 1);
      chk("abort_busy_stays_low", {31'd0, busy_out}, 0);

`ifdef SERIAL_TX_PARITY_EN
      // 6: parity frames, 07 -> parity 1, 03 -> parity 0
      @(negedge clock);
      data_in = 8'h07;
      wren_in = 1'b1;
      exp_q.push_back({1'b1, 8'h07});
      @(posedge clock); #1;
      acc = cyc;
      @(negedge clock);
      wren_in = 1'b0;
      wait_until(acc + 44);
      chk("par_busy_last_stop", {31'd0, busy_out}, 1);
      wait_until(acc + 45);
      chk("par_busy_after_44", {31'd0, busy_out}, 0);
      wait_drain(200);
      @(negedge clock);
      data_in = 8'h03;
      wren_in = 1'b1;
      exp_q.push_back({1'b0, 8'h03});
      @(negedge clock);
      wren_in = 1'b0;
      wait_drain(200);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_tx_buffer.md
Name: serial_tx_buffer

Overview:
- Downstream consumer of the processor's serial output port.
- Accepts bytes on the processor's write strobe (serial_out / serial_wren_out) and applies backpressure through the processor's serial_ready_in.
- Buffers bytes in a small FIFO and shifts each one out as an 8N1 UART frame on a single tx line, LSB first.
- Used on-board for console output and in benches as a byte monitor.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 16, clock cycles per UART bit; minimum 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  byte from the processor's serial_out.
- wren_in  input  1  write strobe from the processor's serial_wren_out.
- ready_out  output  1  to the processor's serial_ready_in; high means a byte will be accepted.
- tx_out  output  1  UART line; idles high.
- busy_out  output  1  high while a frame is being shifted or the FIFO is non-empty.
- count_out  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow_out  output  1  sticky flag: a write was attempted while full.

Behaviour:
Reset:
- Synchronous, active-high. All registers are updated by reset regardless of any other input.
- During reset and after it: tx_out=1, count_out=0, overflow_out=0, busy_out=0, FSM=IDLE, read and write pointers=0.
- ready_out is combinational: ready_out = (count != DEPTH). It is therefore 1 out of reset.
- Asserting reset mid-frame aborts the frame. tx_out returns to 1 at the next edge and FIFO contents are discarded.

FIFO:
- Push when wren_in && ready_out at a rising edge.
- wren_in while full: byte dropped, count unchanged, overflow_out set to 1. It stays 1 until reset.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full is evaluated on the pre-edge count, so a write while full is rejected even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH.

TX FSM (states IDLE, START, DATA, STOP):
- Bit timer counts 0..CLKS_PER_BIT-1. Bit index counts 0..7.
- IDLE: tx_out=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the timer, go to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx_out = shift[0] for CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. At the end of STOP:
  - FIFO non-empty: pop directly and go to START (back-to-back frames, no idle gap).
  - FIFO empty: go to IDLE.
- tx_out is registered, so it changes only on clock edges.

Latency and frame length:
- Write accepted at edge k: count=1 after edge k. The pop happens at edge k+1, and tx_out=0 from edge k+1.
- Frame length is 10*CLKS_PER_BIT cycles.
- busy_out = (state != IDLE) || (count != 0).

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx_out = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT cycles.
- Not defined: no PARITY state exists and frames are 8N1 as above.

Test Plan:
All scenarios use DEPTH=4 and CLKS_PER_BIT=4.
1. Reset held 20 cycles, then released:
   - During reset and after release: tx_out=1, ready_out=1, count_out=0, overflow_out=0, busy_out=0.
2. Single write 8'hA5 one cycle after reset release:
   - tx_out=0 starting one cycle after the accepting edge, held 4 cycles.
   - Then data bits 1,0,1,0,0,1,0,1, each 4 cycles.
   - Then stop bit 1 for 4 cycles; busy_out drops after the stop bit.
3. Five consecutive writes 8'h01..8'h05 with wren_in held high:
   - ready_out=0 once count_out reaches 4.
   - Overflow is set only if a write arrives while count_out=4; the bench checks for exactly that.
   - Frames are back-to-back with no idle cycles; the decoded byte sequence equals the accepted bytes in order.
4. Write while full:
   - Byte dropped, overflow_out=1 and remains 1 through later traffic.
   - overflow_out clears only on reset.
5. Reset asserted mid-DATA of 8'hFF with 2 bytes queued:
   - At the next edge: tx_out=1, count_out=0, FSM=IDLE.
   - No further frames are emitted.
6. With SERIAL_TX_PARITY_EN defined, write 8'h07:
   - Parity bit = 1, frame length 44 cycles.
   - Byte 8'h03 gives parity 0.
